// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment display.
// Owns an 8-entry digit buffer {blank, value[3:0]}. It steps the active anode every
// 2^DIV_W cycles and presents the scanned digit's code to the segment decoder.
// Two writers (A, B) share the buffer through a round-robin valid/ready port.
//
// Optional feature macro: SEG_GHOST_BLANK_EN
//   When defined, anodes are held dark for BLANK_CYC cycles after every digit change
//   (and after reset) to suppress ghosting. digit_val still switches immediately.
module seg_scan_ctrl #(
    parameter int unsigned DIV_W     = 17,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    // writer A
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [2:0] a_digit,
    input  logic [3:0] a_value,
    input  logic       a_blank,
    // writer B
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [2:0] b_digit,
    input  logic [3:0] b_value,
    input  logic       b_blank,
    // display side
    output logic [7:0] anodes,
    output logic [3:0] digit_val,
    output logic [2:0] scan_idx,
    output logic       frame_tick
);

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             cnt_wrap;
    logic [2:0]       scan_q;
    logic             frame_q;

    assign cnt_wrap = &cnt_q;
    assign cnt_d    = cnt_q + DIV_W'(1);

    // Prescaler, digit index and frame pulse; the pulse marks the first cycle after 7->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            scan_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= cnt_wrap && (scan_q == 3'd7);
            if (cnt_wrap) begin
                scan_q <= scan_q + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    // last_b_q = 1 means B was granted last, so A wins the next tie.
    logic       last_b_q;
    logic       a_fire;
    logic       b_fire;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [3:0] wr_val;
    logic       wr_blank;

    // Round-robin grant; both readys are forced low while in reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                a_ready = last_b_q;
                b_ready = !last_b_q;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;

    // Select the single write that can complete this cycle.
    always_comb begin
        wr_en    = a_fire || b_fire;
        wr_idx   = a_digit;
        wr_val   = a_value;
        wr_blank = a_blank;
        if (b_fire) begin
            wr_idx   = b_digit;
            wr_val   = b_value;
            wr_blank = b_blank;
        end
    end

    // Last-grant pointer moves only on a completed transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else if (a_fire) begin
            last_b_q <= 1'b0;
        end else if (b_fire) begin
            last_b_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit buffer
    // ------------------------------------------------------------------
    logic [3:0] val_q [8];
    logic [7:0] blank_q;

    // Buffer storage; writes are independent of the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                val_q[i] <= 4'h0;
            end
            blank_q <= 8'h00;
        end else if (wr_en) begin
            val_q[wr_idx]   <= wr_val;
            blank_q[wr_idx] <= wr_blank;
        end
    end

    // ------------------------------------------------------------------
    // Ghost blanking
    // ------------------------------------------------------------------
    logic ghost_active;

`ifdef SEG_GHOST_BLANK_EN
    logic [DIV_W-1:0] ghost_q;

    // Dead-time counter reloaded on every digit change and on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghost_q <= DIV_W'(BLANK_CYC);
        end else if (cnt_wrap) begin
            ghost_q <= DIV_W'(BLANK_CYC);
        end else if (ghost_q != '0) begin
            ghost_q <= ghost_q - DIV_W'(1);
        end
    end

    assign ghost_active = (ghost_q != '0);
`else
    logic unused_blank_cyc;

    assign unused_blank_cyc = ^BLANK_CYC;
    assign ghost_active     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Display drive: value always follows the scan; anode dark when blanked.
    always_comb begin
        digit_val = val_q[scan_q];
        anodes    = 8'h01 << scan_q;
        if (blank_q[scan_q] || ghost_active) begin
            anodes = 8'h00;
        end
    end

    assign scan_idx   = scan_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl. A cycle-level reference model derived from the
// display behaviour produces expected outputs, which are queued when stimulus is driven
// and popped when the DUT outputs are sampled.
module tb_seg_scan_ctrl;

`ifdef SEG_GHOST_BLANK_EN
    localparam int unsigned DIV_W     = 3;
    localparam int unsigned BLANK_CYC = 2;
    localparam bit          GHOST     = 1'b1;
`else
    localparam int unsigned DIV_W     = 2;
    localparam int unsigned BLANK_CYC = 16;
    localparam bit          GHOST     = 1'b0;
`endif
    localparam int unsigned DWELL = 1 << DIV_W;
    localparam int unsigned FRAME = 8 * DWELL;

    logic       clk;
    logic       rst;
    logic       a_valid, a_ready, a_blank;
    logic [2:0] a_digit;
    logic [3:0] a_value;
    logic       b_valid, b_ready, b_blank;
    logic [2:0] b_digit;
    logic [3:0] b_value;
    logic [7:0] anodes;
    logic [3:0] digit_val;
    logic [2:0] scan_idx;
    logic       frame_tick;

    seg_scan_ctrl #(
        .DIV_W     (DIV_W),
        .BLANK_CYC (BLANK_CYC)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_digit    (a_digit),
        .a_value    (a_value),
        .a_blank    (a_blank),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_digit    (b_digit),
        .b_value    (b_value),
        .b_blank    (b_blank),
        .anodes     (anodes),
        .digit_val  (digit_val),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         known;
        logic [7:0] an;
        logic [3:0] dv;
        logic [2:0] si;
        logic       ft;
        logic       ar;
        logic       br;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit       m_known = 1'b0;
    int       m_cnt   = 0;
    int       m_scan  = 0;
    bit [3:0] m_val [8];
    bit [7:0] m_blank = 8'h00;
    bit       m_last_b = 1'b1;
    bit       m_frame = 1'b0;
    int       m_ghost = 0;

    // Last sampled DUT outputs, for scenario-level checks
    logic [7:0] an_s;
    logic [3:0] dv_s;
    logic [2:0] si_s;
    logic       ft_s, ar_s, br_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, queue expectation, sample/compare, advance the model.
    task automatic cyc(input logic r,
                       input logic av, input logic [2:0] ad, input logic [3:0] avl,
                       input logic ab,
                       input logic bv, input logic [2:0] bd, input logic [3:0] bvl,
                       input logic bb);
        exp_t e;
        exp_t g;
        bit   fa, fb, wrap;
        @(negedge clk);
        rst = r;
        a_valid = av; a_digit = ad; a_value = avl; a_blank = ab;
        b_valid = bv; b_digit = bd; b_value = bvl; b_blank = bb;

        e.known = m_known;
        e.dv    = m_val[m_scan];
        e.si    = 3'(m_scan);
        e.ft    = m_frame;
        e.an    = (m_blank[m_scan] || m_ghost != 0) ? 8'h00 : 8'(1 << m_scan);
        e.ar    = !r && av && (!bv || m_last_b);
        e.br    = !r && bv && (!av || !m_last_b);
        sb.push_back(e);

        #1;
        an_s = anodes; dv_s = digit_val; si_s = scan_idx;
        ft_s = frame_tick; ar_s = a_ready; br_s = b_ready;
        g = sb.pop_front();
        check("a_ready", {31'd0, ar_s}, {31'd0, g.ar});
        check("b_ready", {31'd0, br_s}, {31'd0, g.br});
        check("one_ready", {31'd0, ar_s & br_s}, 32'd0);
        if (g.known) begin
            check("scan_idx", {29'd0, si_s}, {29'd0, g.si});
            check("anodes", {24'd0, an_s}, {24'd0, g.an});
            check("digit_val", {28'd0, dv_s}, {28'd0, g.dv});
            check("frame_tick", {31'd0, ft_s}, {31'd0, g.ft});
        end

        fa = e.ar;
        fb = e.br;
        if (r) begin
            m_known  = 1'b1;
            m_cnt    = 0;
            m_scan   = 0;
            for (int i = 0; i < 8; i++) m_val[i] = 4'h0;
            m_blank  = 8'h00;
            m_last_b = 1'b1;
            m_frame  = 1'b0;
            m_ghost  = GHOST ? int'(BLANK_CYC) : 0;
        end else begin
            wrap    = (m_cnt == int'(DWELL) - 1);
            m_frame = wrap && (m_scan == 7);
            if (fa) begin
                m_val[ad] = avl; m_blank[ad] = ab; m_last_b = 1'b0;
            end
            if (fb) begin
                m_val[bd] = bvl; m_blank[bd] = bb; m_last_b = 1'b1;
            end
            m_cnt = wrap ? 0 : m_cnt + 1;
            if (wrap) m_scan = (m_scan + 1) % 8;
            if (GHOST) begin
                if (wrap) m_ghost = int'(BLANK_CYC);
                else if (m_ghost != 0) m_ghost--;
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0);
    endtask

    initial begin
        int         n_frame;
        int         frame_at;
        logic [3:0] v3;
        logic [7:0] an3;
        logic [7:0] an5_or;
        logic [7:0] an4;
        logic [3:0] v6;
        bit         found;

        rst = 1'b1;
        a_valid = 1'b0; a_digit = '0; a_value = '0; a_blank = 1'b0;
        b_valid = 1'b0; b_digit = '0; b_value = '0; b_blank = 1'b0;

        // Reset, with a write offered during reset that must be ignored
        cyc(1'b1, 1'b1, 3'd1, 4'h7, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 3'd2, 4'h7, 1'b0);

        // Free run: one frame pulse, at the first cycle of the second frame
        n_frame  = 0;
        frame_at = -1;
        for (int i = 0; i < int'(FRAME) + 8; i++) begin
            idle();
            if (i == 0) begin
                check("rst_scan", {29'd0, si_s}, 32'd0);
                check("rst_anodes", {24'd0, an_s}, GHOST ? 32'h00 : 32'h01);
                check("rst_ftick", {31'd0, ft_s}, 32'd0);
            end
            if (ft_s === 1'b1) begin
                n_frame++;
                frame_at = i;
            end
        end
        check("frame_count", n_frame, 1);
        check("frame_pos", frame_at, FRAME);

        // Writer A alone: digit 3 = A
        cyc(1'b0, 1'b1, 3'd3, 4'hA, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0);
        check("a_only_ready", {31'd0, ar_s}, 32'd1);
        v3 = 4'h0; an3 = 8'h00;
        for (int i = 0; i < int'(FRAME); i++) begin
            idle();
            if (si_s == 3'd3) begin v3 = dv_s; an3 = an_s; end
        end
        check("d3_value", {28'd0, v3}, 32'hA);
        check("d3_anodes", {24'd0, an3}, 32'h08);

        // Writer B alone: digit 5 blanked; leaves last grant at B
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 3'd5, 4'h5, 1'b1);
        check("b_only_ready", {31'd0, br_s}, 32'd1);
        an5_or = 8'h00; an4 = 8'h00;
        for (int i = 0; i < int'(FRAME); i++) begin
            idle();
            if (si_s == 3'd5) an5_or = an5_or | an_s;
            if (si_s == 3'd4) an4 = an_s;
        end
        check("d5_dark", {24'd0, an5_or}, 32'h00);
        check("d4_lit", {24'd0, an4}, 32'h10);

        // Contention: both valid for 4 cycles, grants must alternate A,B,A,B
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 3'(i), 4'(8 + i), 1'b0,
                1'b1, (i == 1) ? 3'd6 : 3'd7, 4'(12 + i), 1'b0);
            check("alt_a", {31'd0, ar_s}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_b", {31'd0, br_s}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        v6 = 4'h0;
        for (int i = 0; i < int'(FRAME); i++) begin
            idle();
            if (si_s == 3'd6) v6 = dv_s;
        end
        check("d6_b_write", {28'd0, v6}, 32'hD);

        // Reset at scan 6, cnt 2 with a simultaneous write that must be dropped
        found = 1'b0;
        for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
            if (m_scan == 6 && m_cnt == (DWELL > 2 ? 2 : 0)) found = 1'b1;
            else idle();
        end
        check("rst_point_found", {31'd0, found}, 32'd1);
        cyc(1'b1, 1'b1, 3'd6, 4'hF, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0);
        check("rst_a_ready", {31'd0, ar_s}, 32'd0);
        idle();
        check("post_rst_scan", {29'd0, si_s}, 32'd0);
        check("post_rst_anodes", {24'd0, an_s}, GHOST ? 32'h00 : 32'h01);
        check("post_rst_val", {28'd0, dv_s}, 32'h0);
        v6 = 4'h5;
        for (int i = 0; i < int'(FRAME); i++) begin
            idle();
            if (si_s == 3'd6) v6 = dv_s;
        end
        check("d6_cleared", {28'd0, v6}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1, "timeout");
    end

endmodule
